// File: rtl/ppu_pkt_filter.sv
// ppu_pkt_filter: store-and-forward checker/filter for the PPU video-word stream.
// Buffers each packet, validates header, length and checksum, then forwards, flags or drops it.
module ppu_pkt_filter #(
    parameter int              DW         = 16,
    parameter logic [DW-1:0]   HDR_A      = 16'h55d4,
    parameter logic [DW-1:0]   HDR_B      = 16'h55d5,
    parameter int              MIN_LEN    = 16,
    parameter int              MAX_LEN    = 600,
    parameter int              BUF_DEPTH  = 2048,
    parameter int              DESC_DEPTH = 8,
    parameter bit              DROP_BAD   = 1'b1,
    parameter int              CNT_W      = 16
) (
    input  logic             clk_100m,
    input  logic             rst_n,
    input  logic             vid_in,
    input  logic [DW-1:0]    data_in,
    input  logic             cnt_clr,
    output logic             vid_out,
    output logic [DW-1:0]    data_out,
    output logic             err_out,
    output logic [CNT_W-1:0] good_cnt,
    output logic [CNT_W-1:0] hdr_err_cnt,
    output logic [CNT_W-1:0] len_err_cnt,
    output logic [CNT_W-1:0] sum_err_cnt,
    output logic [CNT_W-1:0] ovf_cnt,
    output logic             busy
);
    localparam int AW  = $clog2(BUF_DEPTH);
    localparam int DAW = $clog2(DESC_DEPTH);
    localparam int LW  = $clog2(MAX_LEN + 4);

    localparam logic [LW-1:0]  MIN_WORDS = LW'(MIN_LEN + 2);
    localparam logic [LW-1:0]  MAX_WORDS = LW'(MAX_LEN + 2);
    localparam logic [LW-1:0]  SAT_WORDS = LW'(MAX_LEN + 3);
    localparam logic [AW:0]    PTR_FULL  = (AW+1)'(BUF_DEPTH);
    localparam logic [DAW:0]   DESC_FULL = (DAW+1)'(DESC_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} out_state_t;

    // Packet RAM and descriptor FIFO storage
    logic [DW-1:0] mem      [BUF_DEPTH];
    logic [LW-1:0] desc_len [DESC_DEPTH];
    logic          desc_err [DESC_DEPTH];

    // Receive side
    logic          vid_in_d, rx_active, hdr_ok, hold_valid, rx_ovf;
    logic [LW-1:0] rx_words;
    logic [DW-1:0] hold, sum;
    logic [AW:0]   wr_ptr, wr_base;

    // Descriptor FIFO and output side
    logic [DAW-1:0] desc_wr, desc_rd;
    logic [DAW:0]   desc_count;
    logic [AW:0]    rd_ptr;
    logic [LW-1:0]  tx_left;
    logic           tx_err;
    out_state_t     state;

    logic          rx_start, rx_word, rx_end, desc_full, space_ok, wr_en;
    logic          len_ok, sum_ok, pkt_good, push, pop;
    logic [DW:0]   sum_add;
    logic [DW-1:0] sum_next, exp_tail;
    logic [LW-1:0] commit_len;

    assign rx_start  = vid_in & ~vid_in_d;
    assign rx_word   = vid_in & rx_active;
    assign rx_end    = rx_active & ~vid_in;
    assign desc_full = (desc_count == DESC_FULL);
    assign space_ok  = ((wr_ptr - rd_ptr) != PTR_FULL);
    assign wr_en     = (rx_start & ~desc_full & space_ok)
                     | (rx_word & ~rx_ovf & space_ok & (rx_words < MAX_WORDS));

    // One's-complement accumulate: the carry out of the top bit wraps back into bit 0.
    assign sum_add  = {1'b0, sum} + {1'b0, hold};
    assign sum_next = sum_add[DW-1:0] + DW'(sum_add[DW]);
    assign exp_tail = (sum == '1) ? '1 : ~sum;

    assign len_ok     = (rx_words >= MIN_WORDS) && (rx_words <= MAX_WORDS);
    assign sum_ok     = (hold == exp_tail);
    assign pkt_good   = hdr_ok & len_ok & sum_ok;
    assign push       = rx_end & ~rx_ovf & (pkt_good | !DROP_BAD);
    assign commit_len = (rx_words > MAX_WORDS) ? MAX_WORDS : rx_words;
    assign pop        = (state == S_IDLE) && (desc_count != '0);

    assign busy = vid_in | rx_active | (desc_count != '0) | (state != S_IDLE);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            // Starting "high" hides a packet already in flight until vid_in has been seen low.
            vid_in_d   <= 1'b1;
            rx_active  <= 1'b0;
            hdr_ok     <= 1'b0;
            hold_valid <= 1'b0;
            rx_ovf     <= 1'b0;
            rx_words   <= '0;
            hold       <= '0;
            sum        <= '0;
            wr_ptr     <= '0;
            wr_base    <= '0;
        end else begin
            vid_in_d <= vid_in;
            if (rx_start) begin
                rx_active  <= 1'b1;
                hdr_ok     <= (data_in == HDR_A) || (data_in == HDR_B);
                hold_valid <= 1'b0;
                sum        <= '0;
                rx_words   <= LW'(1);
                rx_ovf     <= desc_full | ~space_ok;
            end else if (rx_word) begin
                if (rx_words != SAT_WORDS)
                    rx_words <= rx_words + LW'(1);
                // The newest word sits in hold, so the tail never reaches the sum.
                if (hold_valid)
                    sum <= sum_next;
                hold       <= data_in;
                hold_valid <= 1'b1;
                if (~rx_ovf & ~space_ok & (rx_words < MAX_WORDS))
                    rx_ovf <= 1'b1;
            end else if (rx_end) begin
                rx_active <= 1'b0;
            end

            if (rx_end) begin
                if (push)
                    wr_base <= wr_ptr;
                else
                    wr_ptr  <= wr_base;
            end else if (wr_en) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
        end
    end

    // NOTE: RAM arrays have no reset so they map onto memory macros; each entry is written before it is read.
    always_ff @(posedge clk_100m) begin
        if (wr_en)
            mem[wr_ptr[AW-1:0]] <= data_in;
        if (push) begin
            desc_len[desc_wr] <= commit_len;
            desc_err[desc_wr] <= ~pkt_good;
        end
    end

    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            desc_wr    <= '0;
            desc_rd    <= '0;
            desc_count <= '0;
        end else begin
            if (push)
                desc_wr <= desc_wr + DAW'(1);
            if (pop)
                desc_rd <= desc_rd + DAW'(1);
            if (push && !pop)
                desc_count <= desc_count + (DAW+1)'(1);
            else if (pop && !push)
                desc_count <= desc_count - (DAW+1)'(1);
        end
    end

    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            good_cnt    <= '0;
            hdr_err_cnt <= '0;
            len_err_cnt <= '0;
            sum_err_cnt <= '0;
            ovf_cnt     <= '0;
        end else if (cnt_clr) begin
            good_cnt    <= '0;
            hdr_err_cnt <= '0;
            len_err_cnt <= '0;
            sum_err_cnt <= '0;
            ovf_cnt     <= '0;
        end else if (rx_end) begin
            if (rx_ovf)
                ovf_cnt     <= sat_inc(ovf_cnt);
            else if (!hdr_ok)
                hdr_err_cnt <= sat_inc(hdr_err_cnt);
            else if (!len_ok)
                len_err_cnt <= sat_inc(len_err_cnt);
            else if (!sum_ok)
                sum_err_cnt <= sat_inc(sum_err_cnt);
            else
                good_cnt    <= sat_inc(good_cnt);
        end
    end

    // Output FSM: data_out is the registered RAM read, so it lines up with vid_out.
    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            vid_out  <= 1'b0;
            data_out <= '0;
            err_out  <= 1'b0;
            rd_ptr   <= '0;
            tx_left  <= '0;
            tx_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    vid_out <= 1'b0;
                    err_out <= 1'b0;
                    if (pop) begin
                        tx_left <= desc_len[desc_rd];
                        tx_err  <= desc_err[desc_rd];
                        state   <= S_SEND;
                    end
                end
                S_SEND: begin
                    vid_out  <= 1'b1;
                    data_out <= mem[rd_ptr[AW-1:0]];
                    rd_ptr   <= rd_ptr + (AW+1)'(1);
                    tx_left  <= tx_left - LW'(1);
                    err_out  <= tx_err & (tx_left == LW'(1));
                    if (tx_left == LW'(1))
                        state <= S_GAP;
                end
                S_GAP: begin
                    vid_out <= 1'b0;
                    err_out <= 1'b0;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ppu_pkt_filter.sv
// Scoreboard bench for ppu_pkt_filter: a drop-mode instance (a) and a forward-with-flag
// instance with a 2-entry descriptor FIFO (b), driven by directed packets.
`timescale 1ns/1ps
module tb_ppu_pkt_filter;
    logic clk_100m = 1'b0;
    logic rst_n    = 1'b0;
    always #5 clk_100m = ~clk_100m;

    logic        vid_in_a = 1'b0, cnt_clr_a = 1'b0, vid_in_b = 1'b0, cnt_clr_b = 1'b0;
    logic [15:0] data_in_a = '0, data_in_b = '0;
    logic        vid_out_a, err_out_a, busy_a, vid_out_b, err_out_b, busy_b;
    logic [15:0] data_out_a, data_out_b;
    logic [15:0] good_a, hdr_a, len_a, sum_a, ovf_a;
    logic [15:0] good_b, hdr_b, len_b, sum_b, ovf_b;

    ppu_pkt_filter dut_a (
        .clk_100m(clk_100m), .rst_n(rst_n), .vid_in(vid_in_a), .data_in(data_in_a),
        .cnt_clr(cnt_clr_a), .vid_out(vid_out_a), .data_out(data_out_a), .err_out(err_out_a),
        .good_cnt(good_a), .hdr_err_cnt(hdr_a), .len_err_cnt(len_a), .sum_err_cnt(sum_a),
        .ovf_cnt(ovf_a), .busy(busy_a)
    );

    ppu_pkt_filter #(.DROP_BAD(1'b0), .DESC_DEPTH(2)) dut_b (
        .clk_100m(clk_100m), .rst_n(rst_n), .vid_in(vid_in_b), .data_in(data_in_b),
        .cnt_clr(cnt_clr_b), .vid_out(vid_out_b), .data_out(data_out_b), .err_out(err_out_b),
        .good_cnt(good_b), .hdr_err_cnt(hdr_b), .len_err_cnt(len_b), .sum_err_cnt(sum_b),
        .ovf_cnt(ovf_b), .busy(busy_b)
    );

    typedef struct packed {
        logic [15:0] data;
        logic        err;
        logic        first;
        logic        last;
    } exp_t;

    exp_t        exp_a[$];
    exp_t        exp_b[$];
    logic [15:0] tx[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          tail_cyc = 0;
    int          rise_cyc[2];
    int          pkts_out[2];
    logic        prev_vid[2];
    logic        mon_en = 1'b0;
    logic        clr_on_commit = 1'b0;

    always @(posedge clk_100m) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic mon_step(input int sel, input logic vid, input logic [15:0] data, input logic err);
        exp_t e;
        if (vid) begin
            if (!prev_vid[sel])
                rise_cyc[sel] = cyc;
            if ((sel == 0 && exp_a.size() == 0) || (sel == 1 && exp_b.size() == 0)) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word dut%0d: got %0h, expected no output", sel, data);
            end else begin
                if (sel == 0) e = exp_a.pop_front();
                else          e = exp_b.pop_front();
                check($sformatf("data_out%0d", sel), data, e.data);
                check($sformatf("err_out%0d", sel), err, e.err);
                check($sformatf("framing%0d", sel), prev_vid[sel], !e.first);
                if (e.last)
                    pkts_out[sel]++;
            end
        end else if (prev_vid[sel]) begin
            check($sformatf("err_idle%0d", sel), err, 1'b0);
        end
        prev_vid[sel] = vid;
    endtask

    always @(negedge clk_100m) begin
        if (mon_en) begin
            mon_step(0, vid_out_a, data_out_a, err_out_a);
            mon_step(1, vid_out_b, data_out_b, err_out_b);
        end
    end

    task automatic build(input logic [15:0] hdr, input int n, input logic [15:0] fill);
        tx.delete();
        tx.push_back(hdr);
        for (int i = 0; i < n; i++)
            tx.push_back(fill);
    endtask

    // Appends the valid tail for the payload currently in tx (words after the header).
    task automatic add_tail();
        int unsigned s = 0;
        for (int i = 1; i < tx.size(); i++)
            s += tx[i];
        while (s > 32'hFFFF)
            s = (s & 32'hFFFF) + (s >> 16);
        tx.push_back((s == 32'hFFFF) ? 16'hFFFF : ~s[15:0]);
    endtask

    task automatic push_exp(input int sel, input bit err);
        exp_t e;
        int   n;
        n = (tx.size() > 602) ? 602 : tx.size();
        for (int i = 0; i < n; i++) begin
            e.data  = tx[i];
            e.err   = err && (i == n - 1);
            e.first = (i == 0);
            e.last  = (i == n - 1);
            if (sel == 0) exp_a.push_back(e);
            else          exp_b.push_back(e);
        end
    endtask

    task automatic send(input int sel, input bit fwd, input bit err);
        if (fwd)
            push_exp(sel, err);
        foreach (tx[i]) begin
            @(posedge clk_100m); #1;
            if (sel == 0) begin vid_in_a = 1'b1; data_in_a = tx[i]; end
            else          begin vid_in_b = 1'b1; data_in_b = tx[i]; end
        end
        tail_cyc = cyc + 1;
        @(posedge clk_100m); #1;
        vid_in_a  = 1'b0;
        vid_in_b  = 1'b0;
        data_in_a = '0;
        data_in_b = '0;
        cnt_clr_a = clr_on_commit;
        if (clr_on_commit) begin
            @(posedge clk_100m); #1;
            cnt_clr_a     = 1'b0;
            clr_on_commit = 1'b0;
        end
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_a.size() != 0 || exp_b.size() != 0 || busy_a || busy_b) && n < 3000) begin
            @(posedge clk_100m); #1;
            n++;
        end
        if (n >= 3000) begin
            checks++;
            errors++;
            $display("FAIL %s: drain timeout, pending a=%0d b=%0d", name, exp_a.size(), exp_b.size());
        end
        repeat (3) @(posedge clk_100m);
        #1;
    endtask

    task automatic check_cnts(input string tag, input int sel, input int g, input int h,
                              input int l, input int s, input int o);
        if (sel == 0) begin
            check({tag, "_good"}, good_a, g); check({tag, "_hdr"}, hdr_a, h);
            check({tag, "_len"}, len_a, l);   check({tag, "_sum"}, sum_a, s);
            check({tag, "_ovf"}, ovf_a, o);
        end else begin
            check({tag, "_good"}, good_b, g); check({tag, "_hdr"}, hdr_b, h);
            check({tag, "_len"}, len_b, l);   check({tag, "_sum"}, sum_b, s);
            check({tag, "_ovf"}, ovf_b, o);
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        prev_vid[0] = 1'b0; prev_vid[1] = 1'b0;
        pkts_out[0] = 0;    pkts_out[1] = 0;
        rise_cyc[0] = 0;    rise_cyc[1] = 0;

        // Reset state
        #1;
        check("rst_vid_out_a", vid_out_a, 1'b0);
        check("rst_data_out_a", data_out_a, 16'h0);
        check("rst_err_out_b", err_out_b, 1'b0);
        check_cnts("rst_a", 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk_100m);
        #2 rst_n = 1'b1;
        repeat (2) @(posedge clk_100m);
        #1 mon_en = 1'b1;

        // Good packet: 0x55d5, 20 x 0x0001, tail 0xFFEB
        build(16'h55d5, 20, 16'h0001); tx.push_back(16'hFFEB);
        send(0, 1'b1, 1'b0);
        wait_drain("good_basic");
        check("latency_a", rise_cyc[0], tail_cyc + 3);
        check("pkts_a_basic", pkts_out[0], 1);
        check_cnts("good_basic", 0, 1, 0, 0, 0, 0);

        // Bad checksum dropped by a, rollback leaves wr_ptr after the first packet
        build(16'h55d5, 20, 16'h0001); tx.push_back(16'hFFEC);
        send(0, 1'b0, 1'b0);
        wait_drain("sum_drop");
        check_cnts("sum_drop", 0, 1, 0, 0, 1, 0);
        check("wr_ptr_rollback", 32'(dut_a.wr_ptr), 32'd22);

        // Same packet forwarded with err_out on word 22 by b
        send(1, 1'b1, 1'b1);
        wait_drain("sum_fwd");
        check("pkts_b_sum", pkts_out[1], 1);
        check_cnts("sum_fwd", 1, 0, 0, 0, 1, 0);

        // Header errors, including header-over-length priority
        build(16'h1234, 20, 16'h0001); tx.push_back(16'hFFEB);
        send(0, 1'b0, 1'b0);
        build(16'h1234, 5, 16'h0003); add_tail();
        send(0, 1'b0, 1'b0);
        wait_drain("hdr_err");
        check_cnts("hdr_err", 0, 1, 2, 0, 1, 0);

        // Length errors: N=10, N=622, single-word pulse
        build(16'h55d4, 10, 16'h0002); add_tail();
        send(0, 1'b0, 1'b0);
        build(16'h55d4, 622, 16'h0100); add_tail();
        send(0, 1'b0, 1'b0);
        tx.delete(); tx.push_back(16'h55d4);
        send(0, 1'b0, 1'b0);
        wait_drain("len_err");
        check_cnts("len_err", 0, 1, 2, 3, 1, 0);

        // Checksum corners at N=MIN_LEN and a maximum-length packet
        build(16'h55d4, 0, 16'h0000);
        tx.push_back(16'h8000); tx.push_back(16'h7FFF);
        for (int i = 0; i < 14; i++) tx.push_back(16'h0000);
        tx.push_back(16'hFFFF);
        send(0, 1'b1, 1'b0);
        build(16'h55d5, 0, 16'h0000);
        tx.push_back(16'hFFFF); tx.push_back(16'h0001);
        for (int i = 0; i < 14; i++) tx.push_back(16'h0000);
        tx.push_back(16'hFFFE);
        send(0, 1'b1, 1'b0);
        build(16'h55d4, 600, 16'h0007); add_tail();
        send(0, 1'b1, 1'b0);
        wait_drain("corners");
        check_cnts("corners", 0, 4, 2, 3, 1, 0);

        // Nine back-to-back good packets with 1-cycle gaps
        base = pkts_out[0];
        for (int k = 0; k < 9; k++) begin
            build((k % 2) ? 16'h55d5 : 16'h55d4, 20, 16'(k + 1)); add_tail();
            send(0, 1'b1, 1'b0);
        end
        wait_drain("b2b");
        check("b2b_pkts", pkts_out[0] - base, 9);
        check_cnts("b2b", 0, 13, 2, 3, 1, 0);

        // Descriptor FIFO overflow on b while a long packet is being sent
        base = pkts_out[1];
        build(16'h55d4, 38, 16'h0010); add_tail();
        send(1, 1'b1, 1'b0);
        tx.delete(); tx.push_back(16'h55d4); send(1, 1'b1, 1'b1);
        tx.delete(); tx.push_back(16'h55d5); send(1, 1'b1, 1'b1);
        tx.delete(); tx.push_back(16'hA5A5); send(1, 1'b0, 1'b0);
        tx.delete(); tx.push_back(16'h5A5A); send(1, 1'b0, 1'b0);
        wait_drain("ovf");
        check("ovf_pkts", pkts_out[1] - base, 3);
        check_cnts("ovf", 1, 1, 0, 2, 1, 2);

        // cnt_clr on the same cycle as a good commit
        build(16'h55d5, 20, 16'h0001); tx.push_back(16'hFFEB);
        clr_on_commit = 1'b1;
        send(0, 1'b1, 1'b0);
        wait_drain("cnt_clr");
        check_cnts("cnt_clr", 0, 0, 0, 0, 0, 0);

        // Reset in the middle of SEND, then a normal packet
        build(16'h55d4, 30, 16'h0003); add_tail();
        send(0, 1'b1, 1'b0);
        n = 0;
        while (!vid_out_a && n < 50) begin
            @(posedge clk_100m); #2;
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL reset_wait: vid_out_a never rose");
        end
        repeat (5) @(posedge clk_100m);
        #2;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("rst_mid_vid_out", vid_out_a, 1'b0);
        check("rst_mid_busy", busy_a, 1'b0);
        check_cnts("rst_mid_a", 0, 0, 0, 0, 0, 0);
        check_cnts("rst_mid_b", 1, 0, 0, 0, 0, 0);
        exp_a.delete();
        exp_b.delete();
        prev_vid[0] = 1'b0;
        prev_vid[1] = 1'b0;
        repeat (2) @(posedge clk_100m);
        #2 rst_n = 1'b1;
        repeat (2) @(posedge clk_100m);
        #1 mon_en = 1'b1;
        base = pkts_out[0];
        build(16'h55d5, 20, 16'h0001); tx.push_back(16'hFFEB);
        send(0, 1'b1, 1'b0);
        wait_drain("after_reset");
        check("after_reset_pkts", pkts_out[0] - base, 1);
        check_cnts("after_reset", 0, 1, 0, 0, 0, 0);
        check("final_busy_a", busy_a, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
